// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and helpers for the LED pulse stretcher: channel FSM encoding
// and the counter-width rule used by every channel.
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_stretch_state_e;

  // Counter must hold both on_cycles-1 and gap_cycles-1; never narrower than 1 bit.
  function automatic int stretch_cnt_w(input int on_cycles, input int gap_cycles);
    int longest;
    longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event/brightness inputs and LED outputs of the pulse stretcher, bundled for
// the status/debug source side (master) and the stretcher itself (slave).
interface led_pulse_stretcher_if #(
  parameter int channels_p  = 4,
  parameter int pwm_width_p = 8
);

  logic [channels_p-1:0]  event_i;
  logic [pwm_width_p-1:0] duty_i;
  logic [channels_p-1:0]  active_o;
  logic [channels_p-1:0]  led_o;

  modport master (
    output event_i,
    output duty_i,
    input  active_o,
    input  led_o
  );

  modport slave (
    input  event_i,
    input  duty_i,
    output active_o,
    output led_o
  );

endinterface

// File: rtl/led_stretch_channel.sv
// One LED channel: stretches any event into a fixed ON period followed by a
// guaranteed OFF gap, queueing at most one extra blink while busy.
module led_stretch_channel
  import led_pulse_stretcher_pkg::*;
#(
  parameter int on_cycles_p  = 1 << 20,
  parameter int gap_cycles_p = 1 << 19
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic trig,
  output logic active
);

  localparam int cnt_w_p = stretch_cnt_w(on_cycles_p, gap_cycles_p);
  localparam logic [cnt_w_p-1:0] on_last_p  = cnt_w_p'(on_cycles_p - 1);
  localparam logic [cnt_w_p-1:0] gap_last_p = cnt_w_p'(gap_cycles_p - 1);

  led_stretch_state_e   state_q, state_d;
  logic [cnt_w_p-1:0]   cnt_q, cnt_d;
  logic                 pend_q, pend_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (trig) pend_d = 1'b1;
        if (cnt_q == on_last_p) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w_p'(1);
        end
      end
      GAP: begin
        if (cnt_q == gap_last_p) begin
          // An event in the final gap cycle is consumed directly by the restart.
          cnt_d  = '0;
          pend_d = 1'b0;
          state_d = (pend_q || trig) ? ON : IDLE;
        end else begin
          if (trig) pend_d = 1'b1;
          cnt_d = cnt_q + cnt_w_p'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    active = (state_q == ON);
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Per-channel pulse stretchers feeding the LED pins through a shared PWM dimmer
// and a single output register.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int channels_p   = 4,
  parameter int on_cycles_p  = 1 << 20,
  parameter int gap_cycles_p = 1 << 19,
  parameter int pwm_width_p  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  led_pulse_stretcher_if.slave  bus
);

  logic [channels_p-1:0]  active;
  logic [pwm_width_p-1:0] pwm_cnt_q;
  logic                   pwm_en;
  logic [channels_p-1:0]  led_q;

  for (genvar n = 0; n < channels_p; n++) begin : g_chan
    led_stretch_channel #(
      .on_cycles_p (on_cycles_p),
      .gap_cycles_p(gap_cycles_p)
    ) u_chan (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .trig     (bus.event_i[n]),
      .active   (active[n])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) pwm_cnt_q <= '0;
    else            pwm_cnt_q <= pwm_cnt_q + pwm_width_p'(1);
  end

  // All-ones duty must be fully on, which a plain compare cannot reach.
  always_comb begin
    pwm_en = (pwm_cnt_q < bus.duty_i) || (bus.duty_i == '1);
  end

  // Stage boundary: pin register, one cycle behind active & pwm_en.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) led_q <= '0;
    else            led_q <= active & {channels_p{pwm_en}};
  end

  assign bus.active_o = active;
  assign bus.led_o    = led_q;

endmodule
